tristate_bus_arbiter: RTL and testbench

//  Round-robin owner controller for a shared tri-state wire bus built from bufif1 drivers.

---
 rtl/tristate_bus_arbiter.sv | 176 +++++++++++++++++
 tb/tb_tristate_bus_arbiter.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/tristate_bus_arbiter.sv
// tristate_bus_arbiter
//   Round-robin owner controller for a shared tri-state bus built from bufif1
//   drivers. Grants the bus to one requester at a time and drives that
//   requester's buffer enable. Between owners, every enable is held low for
//   TURNAROUND cycles plus the following idle evaluation cycle, so two
//   drivers can never overlap.
//
// Parameters
//   N_REQ       number of requesters (2..16)
//   TURNAROUND  all-off cycles after a release (>=1)
//   MAX_HOLD    max consecutive owned cycles before a forced release
//               (used only when ARB_TIMEOUT_EN is defined)
//
// Ports
//   clk      rising-edge clock
//   reset    synchronous, active-high reset
//   req      req[i]=1: requester i wants / keeps the bus
//   gnt      registered one-hot (or zero) grant
//   oe       buffer enables, identical to gnt
//   owner    index of the current owner, valid while busy=1
//   busy     1 while a grant is active
//   timeout  1-cycle pulse on a forced release (always 0 without the macro)
//
// Build option
//   ARB_TIMEOUT_EN : enables the MAX_HOLD forced-release timer.

module tristate_bus_arbiter #(
  parameter int unsigned N_REQ      = 4,
  parameter int unsigned TURNAROUND = 1,
  parameter int unsigned MAX_HOLD   = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_REQ-1:0]         req,
  output logic [N_REQ-1:0]         gnt,
  output logic [N_REQ-1:0]         oe,
  output logic [$clog2(N_REQ)-1:0] owner,
  output logic                     busy,
  output logic                     timeout
);

  localparam int unsigned OW = $clog2(N_REQ);
  localparam int unsigned TW = (TURNAROUND > 1) ? $clog2(TURNAROUND) : 1;

  if (N_REQ < 2 || N_REQ > 16 || TURNAROUND < 1 || MAX_HOLD < 1) begin : g_bad_params
    $error("tristate_bus_arbiter: parameter out of range");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN  = 2'd1,
    TURN = 2'd2
  } state_t;

  state_t           state, state_nx;
  logic [OW-1:0]    rr_ptr, rr_ptr_nx;
  logic [OW-1:0]    owner_nx, owner_inc;
  logic [OW-1:0]    winner, cand;
  logic             found;
  logic [N_REQ-1:0] gnt_nx;
  logic             busy_nx, timeout_nx;
  logic [TW-1:0]    turn_cnt, turn_cnt_nx;
  logic             owner_req;
  logic             force_rel;

  // Round-robin scan starting at rr_ptr; first requester found wins.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    cand   = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      cand = OW'((32'(rr_ptr) + i) % N_REQ);
      if (!found && req[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  assign owner_req = req[owner];
  assign owner_inc = (owner == OW'(N_REQ - 1)) ? '0 : owner + OW'(1);

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned HW = $clog2(MAX_HOLD + 1);

  logic [HW-1:0] hold_cnt;

  // hold_cnt holds the number of owned cycles so far: loaded with 1 on the
  // grant edge, so a release fires after exactly MAX_HOLD owned cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_cnt <= '0;
    end else if (state == IDLE && found) begin
      hold_cnt <= HW'(1);
    end else if (state == OWN && hold_cnt != HW'(MAX_HOLD)) begin
      hold_cnt <= hold_cnt + HW'(1);
    end
  end

  // While owned, gnt is one-hot on the owner, so ~gnt masks the owner out.
  assign force_rel = (hold_cnt == HW'(MAX_HOLD)) && (|(req & ~gnt));
`else
  assign force_rel = 1'b0;
`endif

  always_comb begin
    state_nx    = state;
    gnt_nx      = gnt;
    owner_nx    = owner;
    busy_nx     = busy;
    timeout_nx  = 1'b0;
    rr_ptr_nx   = rr_ptr;
    turn_cnt_nx = turn_cnt;
    case (state)
      IDLE: begin
        if (found) begin
          gnt_nx   = N_REQ'(1) << winner;
          owner_nx = winner;
          busy_nx  = 1'b1;
          state_nx = OWN;
        end else begin
          gnt_nx  = '0;
          busy_nx = 1'b0;
        end
      end
      OWN: begin
        if (!owner_req || force_rel) begin
          gnt_nx      = '0;
          busy_nx     = 1'b0;
          rr_ptr_nx   = owner_inc;
          turn_cnt_nx = '0;
          state_nx    = TURN;
          timeout_nx  = force_rel & owner_req;
        end
      end
      TURN: begin
        gnt_nx  = '0;
        busy_nx = 1'b0;
        // Return to IDLE after TURNAROUND cycles; IDLE grants on the next edge.
        if (turn_cnt == TW'(TURNAROUND - 1)) begin
          state_nx = IDLE;
        end else begin
          turn_cnt_nx = turn_cnt + TW'(1);
        end
      end
      default: begin
        gnt_nx   = '0;
        busy_nx  = 1'b0;
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      gnt      <= '0;
      owner    <= '0;
      busy     <= 1'b0;
      timeout  <= 1'b0;
      rr_ptr   <= '0;
      turn_cnt <= '0;
    end else begin
      state    <= state_nx;
      gnt      <= gnt_nx;
      owner    <= owner_nx;
      busy     <= busy_nx;
      timeout  <= timeout_nx;
      rr_ptr   <= rr_ptr_nx;
      turn_cnt <= turn_cnt_nx;
    end
  end

  assign oe = gnt;

endmodule

// File: tb/tb_tristate_bus_arbiter.sv
// Directed bench for tristate_bus_arbiter (N_REQ=4, TURNAROUND=1, MAX_HOLD=8).
// Build with or without ARB_TIMEOUT_EN; the hold/timeout section follows it.

module tb_tristate_bus_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [3:0] oe;
  logic [1:0] owner;
  logic       busy;
  logic       timeout;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  always #5 clk = ~clk;

  tristate_bus_arbiter #(
    .N_REQ      (4),
    .TURNAROUND (1),
    .MAX_HOLD   (8)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .gnt     (gnt),
    .oe      (oe),
    .owner   (owner),
    .busy    (busy),
    .timeout (timeout)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    tick;
    tick;
    reset = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int         order [5] = '{0, 1, 2, 3, 0};
    logic [3:0] e;
    logic [3:0] prev;

    // 1: reset with all requests high
    reset = 1'b1;
    req   = 4'b1111;
    repeat (2) begin
      tick;
      check("rst_gnt", gnt, 4'b0000);
      check("rst_oe", oe, 4'b0000);
      check("rst_busy", busy, 1'b0);
      check("rst_timeout", timeout, 1'b0);
    end
    reset = 1'b0;
    req   = 4'b0000;
    tick;
    check("idle_noreq", gnt, 4'b0000);

    // 2: single requester, latency and turnaround
    req = 4'b0100;
    tick;
    check("t2_gnt", gnt, 4'b0100);
    check("t2_oe", oe, 4'b0100);
    check("t2_owner", owner, 2'd2);
    check("t2_busy", busy, 1'b1);
    for (int i = 1; i <= 4; i++) begin
      tick;
      check("t2_hold", gnt, 4'b0100);
    end
    req = 4'b0000;
    tick;
    check("t2_release", gnt, 4'b0000);
    check("t2_release_busy", busy, 1'b0);
    req = 4'b0001;
    tick;
    check("t2_turn", gnt, 4'b0000);
    tick;
    check("t2_next_gnt", gnt, 4'b0001);
    check("t2_next_owner", owner, 2'd0);
    req = 4'b0000;
    tick;
    tick;
    #2 req = 4'b0010;
    #2 req = 4'b0000;
    tick;
    check("t2_glitch", gnt, 4'b0000);

    // 3: all requesting, round-robin 0,1,2,3,0
    req = 4'b0000;
    do_reset;
    req = 4'b1111;
    tick;
    for (int k = 0; k < 5; k++) begin
      e = 4'b0001 << order[k];
      check("t3_grant", gnt, e);
      check("t3_owner", owner, order[k]);
      tick;
      check("t3_hold", gnt, e);
      tick;
      check("t3_hold", gnt, e);
      req = 4'b1111 & ~e;
      tick;
      check("t3_release", gnt, 4'b0000);
      req = 4'b1111;
      tick;
      check("t3_turn", oe, 4'b0000);
      tick;
    end

    // 4: random requests, bus-safety invariants
    req = 4'b0000;
    do_reset;
    prev = 4'b0000;
    repeat (2000) begin
      req = 4'($urandom_range(0, 15));
      tick;
      check("t4_onehot", ($countones(oe) <= 1), 1'b1);
      check("t4_oe_eq_gnt", oe, gnt);
      check("t4_busy", busy, (gnt != 4'b0000));
      if (busy) check("t4_owner", gnt, 4'b0001 << owner);
      if (prev != 4'b0000 && oe != 4'b0000) check("t4_no_switch", oe, prev);
      if (timeout) check("t4_timeout_idle", gnt, 4'b0000);
      prev = oe;
    end

    // 5: hold limit
    req = 4'b0000;
    do_reset;
    req = 4'b0001;
    tick;
    check("t5_gnt0", gnt, 4'b0001);
    req = 4'b0011;
`ifdef ARB_TIMEOUT_EN
    for (int i = 1; i <= 7; i++) begin
      tick;
      check("t5_hold", gnt, 4'b0001);
      check("t5_no_timeout", timeout, 1'b0);
    end
    tick;
    check("t5_forced", gnt, 4'b0000);
    check("t5_timeout", timeout, 1'b1);
    tick;
    check("t5_turn", gnt, 4'b0000);
    check("t5_pulse_end", timeout, 1'b0);
    tick;
    check("t5_gnt1", gnt, 4'b0010);
    check("t5_owner1", owner, 2'd1);
    req = 4'b0010;
    repeat (20) begin
      tick;
      check("t5_sat_hold", gnt, 4'b0010);
      check("t5_sat_timeout", timeout, 1'b0);
    end
`else
    repeat (50) begin
      tick;
      check("t5_hold", gnt, 4'b0001);
      check("t5_timeout", timeout, 1'b0);
    end
`endif

    // 6: reset mid-OWN and mid-TURN
    req = 4'b0000;
    do_reset;
    req = 4'b1000;
    tick;
    check("t6_gnt3", gnt, 4'b1000);
    check("t6_owner3", owner, 2'd3);
    tick;
    check("t6_hold3", gnt, 4'b1000);
    reset = 1'b1;
    tick;
    check("t6_rst_gnt", gnt, 4'b0000);
    check("t6_rst_oe", oe, 4'b0000);
    check("t6_rst_busy", busy, 1'b0);
    reset = 1'b0;
    req   = 4'b1001;
    tick;
    check("t6_gnt0", gnt, 4'b0001);
    check("t6_owner0", owner, 2'd0);
    check("t6_busy", busy, 1'b1);
    req = 4'b0000;
    tick;
    check("t6_release", gnt, 4'b0000);
    reset = 1'b1;
    tick;
    reset = 1'b0;
    req   = 4'b0010;
    tick;
    check("t6_after_turn_rst", gnt, 4'b0010);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
